// File: rtl/seq_gen_prog_if.sv
// Control, table-write and sample-output signals of the programmable sequence generator.
// The master modport drives stimulus and the slave modport is the generator side.
interface seq_gen_prog_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  logic             en;
  logic [1:0]       mode;
  logic [AW-1:0]    len;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] z;
  logic [AW-1:0]    idx;
  logic             busy;
  logic             done;

  modport master (
    output start, en, mode, len, wr_en, wr_addr, wr_data,
    input  z, idx, busy, done
  );

  modport slave (
    input  start, en, mode, len, wr_en, wr_addr, wr_data,
    output z, idx, busy, done
  );
endinterface

// File: rtl/seq_gen_prog.sv
// Programmable sequence generator: plays a register table out in wrap, one-shot or
// ping-pong order. Outputs are registered from the next-state values, so no pipeline lag.
module seq_gen_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic           clk,
  input logic           reset,
  seq_gen_prog_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [AW-1:0]    idx_r, idx_s;
  logic             dir_r, dir_s;     // 1'b0 = counting up, 1'b1 = counting down
  logic [1:0]       mode_r;
  logic [AW-1:0]    len_r;
  logic [WIDTH-1:0] table_r [DEPTH];
  logic [WIDTH-1:0] z_r, z_s;
  logic             busy_r, done_r;

  // Next state, index and direction
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    dir_s   = dir_r;
    if (bus.start) begin
      state_s = RUN;
      idx_s   = '0;
      dir_s   = 1'b0;
    end else if (state_r == RUN && bus.en) begin
      case (mode_r)
        2'b01: begin
          if (idx_r == len_r) begin
            state_s = DONE;
          end else begin
            idx_s = idx_r + AW'(1);
          end
        end
        2'b10: begin
          if (len_r == '0) begin
            idx_s = '0;
          end else if (!dir_r) begin
            if (idx_r == len_r) begin
              dir_s = 1'b1;
              idx_s = idx_r - AW'(1);
            end else begin
              idx_s = idx_r + AW'(1);
            end
          end else begin
            if (idx_r == '0) begin
              dir_s = 1'b0;
              idx_s = idx_r + AW'(1);
            end else begin
              idx_s = idx_r - AW'(1);
            end
          end
        end
        default: begin
          if (idx_r == len_r) begin
            idx_s = '0;
          end else begin
            idx_s = idx_r + AW'(1);
          end
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Next sample; a write landing on the entry about to be shown is forwarded
  always_comb begin
    z_s = '0;
    if (state_s == IDLE) begin
      z_s = '0;
    end else if (bus.wr_en && bus.wr_addr == idx_s) begin
      z_s = bus.wr_data;
    end else begin
      z_s = table_r[idx_s];
    end
  end

  // Sequencer state, latched run parameters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
      len_r   <= '0;
      z_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      dir_r   <= dir_s;
      if (bus.start) begin
        mode_r <= bus.mode;
        len_r  <= bus.len;
      end
      z_r    <= z_s;
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
    end
  end

  // Sample table, writable in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= '0;
      end
    end else if (bus.wr_en) begin
      table_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.z    = z_r;
  assign bus.idx  = idx_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_seq_gen_prog.sv
// Bench for seq_gen_prog: directed scenarios plus random traffic, checked against a
// position-counter model that derives the index from the selected traversal order.
module tb_seq_gen_prog;
  logic clk;
  logic reset;

  seq_gen_prog_if #(.WIDTH(8),  .DEPTH(16)) bus ();
  seq_gen_prog_if #(.WIDTH(12), .DEPTH(32)) bus2 ();

  seq_gen_prog #(.WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_gen_prog #(.WIDTH(12), .DEPTH(32)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 run, 2 done; m_pos counts advances since the last start
  int m_state;
  int m_pos;
  int m_mode;
  int m_len;
  int m_tab [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_idx();
    int p;
    case (m_mode)
      1: return m_pos;
      2: begin
        if (m_len == 0) return 0;
        p = m_pos % (2 * m_len);
        return (p <= m_len) ? p : 2 * m_len - p;
      end
      default: return m_pos % (m_len + 1);
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pos   = 0;
    m_mode  = 0;
    m_len   = 0;
    for (int i = 0; i < 16; i++) m_tab[i] = 0;
  endtask

  task automatic model_edge();
    if (bus.start) begin
      m_state = 1;
      m_pos   = 0;
      m_mode  = int'(bus.mode);
      m_len   = int'(bus.len);
    end else if (m_state == 1 && bus.en) begin
      if (m_mode == 1 && m_pos == m_len) m_state = 2;
      else m_pos++;
    end
    if (bus.wr_en) m_tab[bus.wr_addr] = int'(bus.wr_data);
  endtask

  task automatic compare_all(input string tag);
    int ei;
    ei = (m_state == 0) ? 0 : exp_idx();
    check_val({tag, ".idx"},  32'(bus.idx),  32'(ei));
    check_val({tag, ".z"},    32'(bus.z),    (m_state == 0) ? 32'd0 : 32'(m_tab[ei]));
    check_val({tag, ".busy"}, 32'(bus.busy), (m_state == 1) ? 32'd1 : 32'd0);
    check_val({tag, ".done"}, 32'(bus.done), (m_state == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.en = 1'b0; bus.mode = 2'b00; bus.len = 4'd0;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'd0;
  endtask

  task automatic do_start(input logic [1:0] md, input logic [3:0] ln);
    bus.start = 1'b1; bus.mode = md; bus.len = ln;
    step("start");
    bus.start = 1'b0; bus.mode = 2'b00; bus.len = 4'd0;
  endtask

  int tab_init [9] = '{0, 3, 12, 34, 59, 233, 24, 1, 155};
  int pp_seq   [9] = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
  int os_z     [4] = '{3, 12, 34, 34};

  initial begin
    idle_inputs();
    bus2.start = 1'b0; bus2.en = 1'b0; bus2.mode = 2'b00; bus2.len = 5'd0;
    bus2.wr_en = 1'b0; bus2.wr_addr = 5'd0; bus2.wr_data = 12'd0;
    reset = 1'b1;
    model_reset();
    #12;
    compare_all("reset");
    reset = 1'b0;

    // idle ignores en
    bus.en = 1'b1;
    step("idle_en");

    // load table while idle
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = 8'(tab_init[i]);
      step("load");
    end
    idle_inputs();

    // wrap over 9 entries, two full periods
    do_start(2'b00, 4'd8);
    check_val("wrap.z0", 32'(bus.z), 32'd0);
    bus.en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step("wrap");
      check_val("wrap.zc", 32'(bus.z), 32'(tab_init[i % 9]));
    end

    // en gating: 1,0,0,1
    do_start(2'b00, 4'd8);
    bus.en = 1'b1; step("gate1");
    bus.en = 1'b0; step("gate0");
    step("gate0b");
    check_val("gate.hold", 32'(bus.idx), 32'd1);
    bus.en = 1'b1; step("gate1b");
    check_val("gate.adv", 32'(bus.idx), 32'd2);
    for (int i = 0; i < 3; i++) step("to5");
    check_val("at5", 32'(bus.idx), 32'd5);
    bus.start = 1'b1; bus.mode = 2'b00; bus.len = 4'd8;
    step("start_en");
    check_val("start_pri", 32'(bus.idx), 32'd0);
    bus.start = 1'b0;

    // one-shot len 3
    do_start(2'b01, 4'd3);
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("oneshot");
      check_val("os.z", 32'(bus.z), 32'(os_z[i]));
    end
    check_val("os.done", 32'(bus.done), 32'd1);
    bus.mode = 2'b10; bus.len = 4'd7;
    for (int i = 0; i < 5; i++) step("os_hold");
    check_val("os.zhold", 32'(bus.z), 32'd34);
    check_val("os.busy", 32'(bus.busy), 32'd0);
    do_start(2'b01, 4'd3);
    check_val("os.restart_z", 32'(bus.z), 32'd0);
    check_val("os.restart_busy", 32'(bus.busy), 32'd1);

    // one-shot len 0
    do_start(2'b01, 4'd0);
    bus.en = 1'b1; step("os0");
    check_val("os0.done", 32'(bus.done), 32'd1);

    // ping-pong len 3 and len 0
    do_start(2'b10, 4'd3);
    check_val("pp.idx0", 32'(bus.idx), 32'd0);
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step("pp");
      check_val("pp.seq", 32'(bus.idx), 32'(pp_seq[i]));
    end
    do_start(2'b10, 4'd0);
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) step("pp0");
    check_val("pp0.idx", 32'(bus.idx), 32'd0);

    // write to the entry being left while advancing
    do_start(2'b11, 4'd8);
    bus.en = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h5A;
    step("wr_leave");
    bus.wr_addr = 4'd2; bus.wr_data = 8'hC3;
    step("wr_next");
    check_val("wr_fwd", 32'(bus.z), 32'hC3);
    idle_inputs();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bus.start   = ($urandom_range(0, 19) == 0);
      bus.en      = ($urandom_range(0, 3) != 0);
      bus.mode    = 2'($urandom_range(0, 3));
      bus.len     = 4'($urandom_range(0, 15));
      bus.wr_en   = ($urandom_range(0, 5) == 0);
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 8'($urandom_range(0, 255));
      step("rand");
    end
    idle_inputs();

    // asynchronous reset mid-run
    do_start(2'b00, 4'd15);
    bus.en = 1'b1;
    step("pre_rst");
    step("pre_rst2");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    #1;
    reset = 1'b0;
    idle_inputs();
    do_start(2'b00, 4'd15);
    bus.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step("cleared");
      check_val("cleared.z", 32'(bus.z), 32'd0);
    end
    idle_inputs();

    // wide instance: wrap at the top index and write-through
    bus2.start = 1'b1; bus2.mode = 2'b00; bus2.len = 5'd31;
    step("w.start");
    bus2.start = 1'b0; bus2.en = 1'b1;
    for (int i = 0; i < 31; i++) step("w.run");
    check_val("w.idx31", 32'(bus2.idx), 32'd31);
    step("w.wrap");
    check_val("w.idx0", 32'(bus2.idx), 32'd0);
    bus2.en = 1'b0; bus2.wr_en = 1'b1; bus2.wr_addr = 5'd0; bus2.wr_data = 12'hABC;
    step("w.write");
    bus2.wr_en = 1'b0;
    check_val("w.z", 32'(bus2.z), 32'hABC);
    check_val("w.busy", 32'(bus2.busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
